// File: rtl/chain_readout_pkg.sv
// Shared definitions for the chain readout block.
// Contents:
//   state_t        - readout FSM states (IDLE, STREAM, DONE)
//   DEFAULT_N      - default number of chained registers
//   DEFAULT_WIDTH  - default bits per register
package chain_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_N     = 5;
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/chain_readout_counter_bank.sv
// Bank of N free-running counters. Entry i resets to i+1 (truncated to WIDTH)
// and increments every non-reset cycle, wrapping modulo 2^WIDTH.
// Ports:
//   clock  - global clock
//   reset  - synchronous, active-high
//   values - all counters flattened; entry i is values[i*WIDTH +: WIDTH]
module counter_bank
  import chain_readout_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  output logic [N*WIDTH-1:0] values
);

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (reset)
        values[i*WIDTH +: WIDTH] <= WIDTH'(i + 1);
      else
        values[i*WIDTH +: WIDTH] <= values[i*WIDTH +: WIDTH] + WIDTH'(1);
    end
  end

endmodule

// File: rtl/chain_readout.sv
// Snapshot-and-stream readout of a counter bank. A start pulse in IDLE copies
// the whole bank into a snapshot, which is then streamed out entry 0 first,
// one entry per accepted valid/ready beat, followed by a one-cycle done pulse.
// Ports:
//   clock, reset - global clock, synchronous active-high reset
//   start        - request snapshot and readout (honoured only in IDLE)
//   busy         - high in STREAM and DONE
//   out_valid    - beat available
//   out_ready    - consumer accepts when out_valid && out_ready
//   out_data     - snapshot value of entry out_index
//   out_index    - entry number of current beat
//   out_last     - high with the beat for entry N-1
//   done         - one-cycle pulse after the last beat is accepted
module chain_readout
  import chain_readout_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 done
);

  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  logic [N*WIDTH-1:0] bank_values;
  logic [WIDTH-1:0]   snap [N];
  logic [IDXW-1:0]    idx;
  state_t             state, state_next;
  logic               accept;
  logic               at_last;

  counter_bank #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_bank (
    .clock  (clock),
    .reset  (reset),
    .values (bank_values)
  );

  assign accept  = (state == STREAM) && out_ready;
  assign at_last = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (out_ready && at_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot and beat index; the bank keeps counting, snap only loads in IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
      for (int unsigned i = 0; i < N; i++)
        snap[i] <= '0;
    end else if (state == IDLE && start) begin
      idx <= '0;
      for (int unsigned i = 0; i < N; i++)
        snap[i] <= bank_values[i*WIDTH +: WIDTH];
    end else if (accept && !at_last) begin
      idx <= idx + IDXW'(1);
    end
  end

  // Outputs decoded from state/idx/snap only; data fields read zero outside STREAM
  always_comb begin
    busy      = (state != IDLE);
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    done      = (state == DONE);
    if (state == STREAM) begin
      out_valid = 1'b1;
      out_data  = snap[idx];
      out_index = idx;
      out_last  = at_last;
    end
  end

endmodule

// File: tb/tb_chain_readout.sv
module tb_chain_readout;

  localparam int N     = 5;
  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic                 clock;
  logic                 reset;
  logic                 start;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [$clog2(N)-1:0] out_index;
  logic                 out_last;
  logic                 done;

  chain_readout #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc counts cycles since the last reset; counter i holds (i+1+cyc) mod 2^W.
  // pending holds the snapshot entries still to be streamed.
  int  cyc = 0;
  int  pending[$];
  bit  done_due = 0;
  bit  model_ok = 0;

  // Observation log used by the literal checks
  int  beats[$];
  int  done_cyc = -1;
  int  done_cnt = 0;

  always @(negedge clock) begin
    if (model_ok) begin
      automatic bit streaming = (pending.size() != 0);
      chk("out_valid", int'(out_valid), int'(streaming));
      chk("busy", int'(busy), int'(streaming || done_due));
      chk("done", int'(done), int'(done_due));
      chk("out_last", int'(out_last), int'(pending.size() == 1));
      if (streaming) begin
        chk("out_data", int'(out_data), pending[0]);
        chk("out_index", int'(out_index), N - pending.size());
      end
      if (out_valid && out_ready) beats.push_back(int'(out_data));
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
    // advance model with inputs the DUT samples at the next posedge
    if (reset) begin
      pending.delete();
      done_due = 0;
      cyc      = 0;
      model_ok = 1;
    end else begin
      if (done_due) begin
        done_due = 0;
      end else if (pending.size() != 0) begin
        if (out_ready) begin
          void'(pending.pop_front());
          if (pending.size() == 0) done_due = 1;
        end
      end else if (start) begin
        for (int i = 0; i < N; i++) pending.push_back((i + 1 + cyc) % MOD);
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit into cycle 0 with an empty log
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step(1);
    reset = 1'b0;
    beats.delete();
    done_cyc = -1;
    done_cnt = 0;
  endtask

  task automatic pulse_start_at(input int k);
    step(k);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 60) begin
      step(1);
      t++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    step(2);
  endtask

  task automatic check_beats(input string name, input int e[N], input int edone);
    chk({name, "_nbeats"}, beats.size(), N);
    for (int i = 0; i < N; i++)
      chk({name, "_beat"}, (i < beats.size()) ? beats[i] : -1, e[i]);
    chk({name, "_done_cyc"}, done_cyc, edone);
    chk({name, "_done_cnt"}, done_cnt, 1);
  endtask

  int e1[N] = '{1, 2, 3, 4, 5};
  int e2[N] = '{4, 5, 6, 7, 8};
  int e3[N] = '{252, 253, 254, 255, 0};

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    step(2);

    // Test 1: start in cycle 0, ready held high
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_index", int'(out_index), 0);
    chk("reset_done", int'(done), 0);
    pulse_start_at(0);
    wait_done();
    check_beats("t1", e1, 6);

    // Test 2: start in cycle 3
    do_reset();
    pulse_start_at(3);
    wait_done();
    check_beats("t2", e2, 3 + N + 1);

    // Test 3: start in cycle 251, entry 4 wraps
    do_reset();
    pulse_start_at(251);
    wait_done();
    check_beats("t3", e3, 251 + N + 1);

    // Test 4: backpressure cycles 1-3, ignored starts during busy
    do_reset();
    out_ready = 1'b0;
    start     = 1'b1;          // cycle 0
    step(1);
    start     = 1'b0;          // cycle 1
    step(1);
    start     = 1'b1;          // cycle 2, STREAM: ignored
    chk("t4_hold_data", int'(out_data), 1);
    step(1);
    start     = 1'b0;          // cycle 3
    step(1);
    out_ready = 1'b1;          // cycle 4
    chk("t4_hold_index", int'(out_index), 0);
    step(5);
    start     = 1'b1;          // cycle 9, DONE: ignored
    chk("t4_done_c9", int'(done), 1);
    step(1);
    start     = 1'b0;          // cycle 10
    chk("t4_idle_c10", int'(busy), 0);
    step(4);
    check_beats("t4", e1, 9);

    // Test 5: reset during STREAM abandons the readout
    do_reset();
    pulse_start_at(0);
    step(2);                   // now in cycle 3
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_nodone", done_cnt, 0);
    beats.delete();
    done_cyc = -1;
    done_cnt = 0;
    start = 1'b1;              // fresh cycle 0
    step(1);
    start = 1'b0;
    wait_done();
    check_beats("t5", e1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
